// File: rtl/keypad_code_queue_if.sv
// Scanner-side and consumer-side signals of the keypad code queue.
// The master modport drives the inputs; the slave modport is the queue itself.
interface keypad_code_queue_if #(
  parameter int DEPTH = 4
);
  logic [3:0]                   Code;
  logic                         Valid;
  logic [3:0]                   Out_Code;
  logic                         Out_Valid;
  logic                         Out_Ready;
  logic [$clog2(DEPTH+1)-1:0]   Count;
  logic                         Full;
  logic                         Overflow;
  logic                         Clr_Ovf;

  modport master (
    output Code, Valid, Out_Ready, Clr_Ovf,
    input  Out_Code, Out_Valid, Count, Full, Overflow
  );

  modport slave (
    input  Code, Valid, Out_Ready, Clr_Ovf,
    output Out_Code, Out_Valid, Count, Full, Overflow
  );
endinterface

// File: rtl/keypad_code_queue.sv
// Debounces repeated keypad codes with a hold-off window and queues the
// accepted codes in a small FIFO drained through a ready/valid handshake.
module keypad_code_queue #(
  parameter int DEPTH          = 4,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  keypad_code_queue_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_HOLD = 1'b1;
  localparam logic [TW-1:0] RELOAD = TW'(HOLDOFF_CYCLES - 1);

  logic [0:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_last_code;
  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_accept;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A repeat of the last code is filtered for as long as the window is open.
  assign w_accept = bus.Valid & ((r_state == S_IDLE) | (bus.Code != r_last_code));
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_pop    = ~w_empty & bus.Out_Ready;
  assign w_push   = w_accept & (~w_full | w_pop);
  assign w_drop   = w_accept & w_full & ~w_pop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_last_code <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Valid) begin
            r_last_code <= bus.Code;
            r_timer     <= RELOAD;
            r_state     <= S_HOLD;
          end
        end
        default: begin
          if (bus.Valid) begin
            r_last_code <= bus.Code;
            r_timer     <= RELOAD;
          end else if (r_timer == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.Code;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.Clr_Ovf) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.Out_Valid = ~w_empty;
  assign bus.Out_Code  = w_empty ? 4'h0 : r_mem[r_rd_ptr];
  assign bus.Count     = r_count;
  assign bus.Full      = w_full;
  assign bus.Overflow  = r_overflow;
endmodule

// File: tb/tb_keypad_code_queue.sv
// Directed bench for keypad_code_queue with HOLDOFF_CYCLES=8, DEPTH=4.
module tb_keypad_code_queue;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  keypad_code_queue_if #(.DEPTH(4)) bus ();

  keypad_code_queue #(
    .DEPTH          (4),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [3:0] c, input logic rdy);
    bus.Code      = c;
    bus.Valid     = 1'b1;
    bus.Out_Ready = rdy;
    tick();
    bus.Valid     = 1'b0;
    bus.Code      = 4'h0;
    bus.Out_Ready = 1'b0;
  endtask

  task automatic pop();
    bus.Out_Ready = 1'b1;
    tick();
    bus.Out_Ready = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 8'(bus.Count), 8'd0);
    check({tag, "_valid"}, 8'(bus.Out_Valid), 8'd0);
    check({tag, "_code"},  8'(bus.Out_Code), 8'd0);
    check({tag, "_full"},  8'(bus.Full), 8'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.Code      = 4'h0;
    bus.Valid     = 1'b0;
    bus.Out_Ready = 1'b0;
    bus.Clr_Ovf   = 1'b0;

    // 1: reset
    idle(3);
    check_empty("rst_held");
    check("rst_ovf", 8'(bus.Overflow), 8'd0);
    reset = 1'b1;
    tick();
    check_empty("rst_rel");
    $display("txn reset: count=%0d ovf=%0d", bus.Count, bus.Overflow);

    // 2: single code then pop
    strobe(4'hA, 1'b0);
    check("t2_valid", 8'(bus.Out_Valid), 8'd1);
    check("t2_code",  8'(bus.Out_Code), 8'hA);
    check("t2_count", 8'(bus.Count), 8'd1);
    pop();
    check("t2_count_after_pop", 8'(bus.Count), 8'd0);
    check("t2_valid_after_pop", 8'(bus.Out_Valid), 8'd0);
    $display("txn single: code A queued and popped");
    idle(12);

    // 3: repeats inside an extended window collapse to one entry
    strobe(4'h5, 1'b0);      // t=0
    idle(2);
    strobe(4'h5, 1'b0);      // t=3
    idle(5);
    strobe(4'h5, 1'b0);      // t=9
    check("t3_count_window", 8'(bus.Count), 8'd1);
    idle(10);
    strobe(4'h5, 1'b0);      // t=20
    check("t3_count_after", 8'(bus.Count), 8'd2);
    check("t3_head0", 8'(bus.Out_Code), 8'h5);
    pop();
    check("t3_head1", 8'(bus.Out_Code), 8'h5);
    pop();
    check("t3_drained", 8'(bus.Count), 8'd0);
    $display("txn holdoff: repeats filtered, count reached 2");
    idle(12);

    // 4: order preserved
    strobe(4'h3, 1'b0);
    idle(1);
    strobe(4'h7, 1'b0);
    check("t4_count", 8'(bus.Count), 8'd2);
    check("t4_head0", 8'(bus.Out_Code), 8'h3);
    pop();
    check("t4_head1", 8'(bus.Out_Code), 8'h7);
    pop();
    check("t4_drained", 8'(bus.Count), 8'd0);
    $display("txn order: 3 then 7");
    idle(12);

    // 5: overflow, clear, drain
    strobe(4'h1, 1'b0);
    strobe(4'h2, 1'b0);
    strobe(4'h3, 1'b0);
    check("t5_not_full", 8'(bus.Full), 8'd0);
    strobe(4'h4, 1'b0);
    check("t5_full", 8'(bus.Full), 8'd1);
    check("t5_count4", 8'(bus.Count), 8'd4);
    check("t5_ovf_pre", 8'(bus.Overflow), 8'd0);
    strobe(4'h5, 1'b0);
    check("t5_ovf_set", 8'(bus.Overflow), 8'd1);
    check("t5_count_drop", 8'(bus.Count), 8'd4);
    bus.Clr_Ovf = 1'b1;
    tick();
    bus.Clr_Ovf = 1'b0;
    check("t5_ovf_clr", 8'(bus.Overflow), 8'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t5_drain%0d", i), 8'(bus.Out_Code), 8'(i));
      pop();
    end
    check("t5_drained", 8'(bus.Count), 8'd0);
    $display("txn overflow: code 5 dropped, drained 1..4");

    // 6: push and pop on a full queue, then reset inside the hold window
    strobe(4'h1, 1'b0);
    strobe(4'h2, 1'b0);
    strobe(4'h3, 1'b0);
    strobe(4'h4, 1'b0);
    strobe(4'h9, 1'b1);
    check("t6_count", 8'(bus.Count), 8'd4);
    check("t6_ovf", 8'(bus.Overflow), 8'd0);
    check("t6_head", 8'(bus.Out_Code), 8'h2);
    pop();
    pop();
    pop();
    check("t6_tail", 8'(bus.Out_Code), 8'h9);
    check("t6_count1", 8'(bus.Count), 8'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_empty("t6_rst");
    strobe(4'h9, 1'b0);
    check("t6_reaccept_count", 8'(bus.Count), 8'd1);
    check("t6_reaccept_code", 8'(bus.Out_Code), 8'h9);
    $display("txn full_pushpop: tail 9, reset cleared queue, 9 re-accepted");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
